// File: rtl/alu_issue_sequencer.sv
// ALU issue sequencer: accepts one ALU instruction word at a time, drives the
// ALU control bundle from the latched word, holds GATEALU for a fixed number
// of cycles, then captures ANSWER and issues a one-cycle register writeback.
module alu_issue_sequencer #(
    parameter int EXEC_CYCLES = 1,   // 1..15
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [15:0]      INSTR,
    input  logic             INSTR_VALID,
    output logic             INSTR_READY,
    input  logic [15:0]      ANSWER,
    output logic [1:0]       ALUK,
    output logic [1:0]       SR2SELECT,
    output logic [2:0]       REGISTER1,
    output logic [2:0]       REGISTER2,
    output logic [7:0]       DATA,
    output logic [6:0]       ADDRESS,
    output logic             GATEALU,
    output logic             LDREG,
    output logic [2:0]       DR,
    output logic [15:0]      RESULT,
    output logic             DONE,
    output logic             ILLEGAL,
    output logic [CNT_W-1:0] RETIRED
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_REJECT = 3'd4
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [1:0] SR2_BAD   = 2'b11;

    state_t           state_q, state_d;
    logic [3:0]       exec_cnt_q, exec_cnt_d;
    logic [15:0]      instr_q;
    logic [15:0]      result_q;
    logic [CNT_W-1:0] retired_q;
    logic             exec_last;

    // The last EXEC cycle is the one whose closing edge samples ANSWER.
    assign exec_last = (state_q == S_EXEC) && (exec_cnt_q == EXEC_LAST);

    // Next-state and control strobes; every strobe defaults low.
    always_comb begin
        state_d     = state_q;
        exec_cnt_d  = exec_cnt_q;
        INSTR_READY = 1'b0;
        GATEALU     = 1'b0;
        LDREG       = 1'b0;
        DONE        = 1'b0;
        ILLEGAL     = 1'b0;
        case (state_q)
            S_IDLE: begin
                INSTR_READY = 1'b1;
                if (INSTR_VALID) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                exec_cnt_d = 4'd0;
                state_d    = (instr_q[13:12] == SR2_BAD) ? S_REJECT : S_EXEC;
            end
            S_EXEC: begin
                GATEALU = 1'b1;
                if (exec_last) begin
                    state_d = S_WB;
                end else begin
                    exec_cnt_d = exec_cnt_q + 4'd1;
                end
            end
            S_WB: begin
                LDREG   = 1'b1;
                DONE    = 1'b1;
                state_d = S_IDLE;
            end
            S_REJECT: begin
                DONE    = 1'b1;
                ILLEGAL = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register and EXEC cycle counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            exec_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            exec_cnt_q <= exec_cnt_d;
        end
    end

    // Instruction latch; it keeps the bundle stable until the next acceptance.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            instr_q <= 16'd0;
        end else if (INSTR_READY && INSTR_VALID) begin
            instr_q <= INSTR;
        end
    end

    // Capture ANSWER and count the retirement on the final EXEC edge so both
    // are already visible during the writeback cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            result_q  <= 16'd0;
            retired_q <= '0;
        end else if (exec_last) begin
            result_q  <= ANSWER;
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    // Fields overlap in the word; all of them are presented in every mode.
    assign ALUK      = instr_q[15:14];
    assign SR2SELECT = instr_q[13:12];
    assign REGISTER1 = instr_q[11:9];
    assign REGISTER2 = instr_q[8:6];
    assign DATA      = instr_q[7:0];
    assign ADDRESS   = instr_q[6:0];
    assign DR        = instr_q[11:9];
    assign RESULT    = result_q;
    assign RETIRED   = retired_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer: instance A uses EXEC_CYCLES=1 with a
// 16-bit counter, instance B uses EXEC_CYCLES=3 with a 4-bit counter.
module tb_alu_issue_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] instr;
    logic        valid;
    logic [15:0] answer;
    logic        sel;   // 0 selects instance A, 1 selects instance B

    logic        ready_a, gate_a, ldreg_a, done_a, illegal_a;
    logic [1:0]  aluk_a, sr2_a;
    logic [2:0]  reg1_a, reg2_a, dr_a;
    logic [7:0]  data_a;
    logic [6:0]  addr_a;
    logic [15:0] result_a, ret_a;

    logic        ready_b, gate_b, ldreg_b, done_b, illegal_b;
    logic [1:0]  aluk_b, sr2_b;
    logic [2:0]  reg1_b, reg2_b, dr_b;
    logic [7:0]  data_b;
    logic [6:0]  addr_b;
    logic [15:0] result_b;
    logic [3:0]  ret_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    alu_issue_sequencer #(.EXEC_CYCLES(1), .CNT_W(16)) u_dut_a (
        .CLK(CLK), .RESET(RESET), .INSTR(instr), .INSTR_VALID(valid && !sel),
        .INSTR_READY(ready_a), .ANSWER(answer), .ALUK(aluk_a), .SR2SELECT(sr2_a),
        .REGISTER1(reg1_a), .REGISTER2(reg2_a), .DATA(data_a), .ADDRESS(addr_a),
        .GATEALU(gate_a), .LDREG(ldreg_a), .DR(dr_a), .RESULT(result_a),
        .DONE(done_a), .ILLEGAL(illegal_a), .RETIRED(ret_a)
    );

    alu_issue_sequencer #(.EXEC_CYCLES(3), .CNT_W(4)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .INSTR(instr), .INSTR_VALID(valid && sel),
        .INSTR_READY(ready_b), .ANSWER(answer), .ALUK(aluk_b), .SR2SELECT(sr2_b),
        .REGISTER1(reg1_b), .REGISTER2(reg2_b), .DATA(data_b), .ADDRESS(addr_b),
        .GATEALU(gate_b), .LDREG(ldreg_b), .DR(dr_b), .RESULT(result_b),
        .DONE(done_b), .ILLEGAL(illegal_b), .RETIRED(ret_b)
    );

    wire        o_ready   = sel ? ready_b   : ready_a;
    wire        o_gate    = sel ? gate_b    : gate_a;
    wire        o_ldreg   = sel ? ldreg_b   : ldreg_a;
    wire        o_done    = sel ? done_b    : done_a;
    wire        o_illegal = sel ? illegal_b : illegal_a;
    wire [1:0]  o_aluk    = sel ? aluk_b    : aluk_a;
    wire [1:0]  o_sr2     = sel ? sr2_b     : sr2_a;
    wire [2:0]  o_reg1    = sel ? reg1_b    : reg1_a;
    wire [2:0]  o_reg2    = sel ? reg2_b    : reg2_a;
    wire [2:0]  o_dr      = sel ? dr_b      : dr_a;
    wire [7:0]  o_data    = sel ? data_b    : data_a;
    wire [6:0]  o_addr    = sel ? addr_b    : addr_a;
    wire [15:0] o_result  = sel ? result_b  : result_a;
    wire [15:0] o_ret     = sel ? {12'd0, ret_b} : ret_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One legal instruction, checked cycle by cycle from acceptance to the idle
    // cycle after writeback.
    task automatic issue(input logic s, input logic [15:0] w, input logic [15:0] ans,
                         input int ec, input logic [1:0] x_sr2, input logic [2:0] x_r1,
                         input logic [7:0] x_dat, input logic [6:0] x_adr,
                         input logic [15:0] x_ret);
        @(negedge CLK);
        sel = s; instr = w; answer = ans; valid = 1'b1;
        check("ready_before_accept", 32'(o_ready), 32'd1);
        @(negedge CLK);
        valid = 1'b0;
        check("decode_ready_low", 32'(o_ready), 32'd0);
        check("decode_gate_low", 32'(o_gate), 32'd0);
        check("decode_aluk", 32'(o_aluk), 32'd3);
        check("decode_sr2", 32'(o_sr2), 32'(x_sr2));
        check("decode_reg1", 32'(o_reg1), 32'(x_r1));
        check("decode_data", 32'(o_data), 32'(x_dat));
        check("decode_addr", 32'(o_addr), 32'(x_adr));
        for (int c = 0; c < ec; c++) begin
            @(negedge CLK);
            check("exec_gate", 32'(o_gate), 32'd1);
            check("exec_ldreg_low", 32'(o_ldreg), 32'd0);
            check("exec_reg1_stable", 32'(o_reg1), 32'(x_r1));
        end
        @(negedge CLK);
        check("wb_gate_low", 32'(o_gate), 32'd0);
        check("wb_ldreg", 32'(o_ldreg), 32'd1);
        check("wb_done", 32'(o_done), 32'd1);
        check("wb_illegal_low", 32'(o_illegal), 32'd0);
        check("wb_dr", 32'(o_dr), 32'(x_r1));
        check("wb_result", 32'(o_result), 32'(ans));
        check("wb_retired", 32'(o_ret), 32'(x_ret));
        @(negedge CLK);
        check("post_ldreg_low", 32'(o_ldreg), 32'd0);
        check("post_done_low", 32'(o_done), 32'd0);
        check("post_ready", 32'(o_ready), 32'd1);
        check("post_result_held", 32'(o_result), 32'(ans));
        check("post_data_held", 32'(o_data), 32'(x_dat));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] words [3];
        logic [15:0] answers [3];
        int acc [3];
        int t;

        RESET = 1'b1; instr = 16'd0; valid = 1'b0; answer = 16'd0; sel = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_gate", 32'(o_gate), 32'd0);
        check("rst_ldreg", 32'(o_ldreg), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_aluk", 32'(o_aluk), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_retired", 32'(o_ret), 32'd0);

        // ADD, data mode, EXEC_CYCLES=1
        issue(1'b0, 16'hD405, 16'h0007, 1, 2'b01, 3'd2, 8'h05, 7'h05, 16'd1);

        // Address mode, EXEC_CYCLES=3: LDREG five cycles after accept
        issue(1'b1, 16'hEA7F, 16'hBEEF, 3, 2'b10, 3'd5, 8'h7F, 7'h7F, 16'd1);
        check("addr_reg2", 32'(o_reg2), 32'd1);

        // Illegal SR2SEL on instance A
        @(negedge CLK);
        sel = 1'b0; instr = 16'hB8AA; answer = 16'h1234; valid = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        check("ill_decode_gate", 32'(o_gate), 32'd0);
        check("ill_decode_done", 32'(o_done), 32'd0);
        @(negedge CLK);
        check("ill_done", 32'(o_done), 32'd1);
        check("ill_illegal", 32'(o_illegal), 32'd1);
        check("ill_gate", 32'(o_gate), 32'd0);
        check("ill_ldreg", 32'(o_ldreg), 32'd0);
        check("ill_retired", 32'(o_ret), 32'd1);
        @(negedge CLK);
        check("ill_post_done", 32'(o_done), 32'd0);
        check("ill_post_ready", 32'(o_ready), 32'd1);
        check("ill_result_held", 32'(o_result), 32'h0007);
        check("ill_retired_after", 32'(o_ret), 32'd1);

        // Back-to-back with VALID held on instance A
        words[0] = 16'h42C0; words[1] = 16'h44C0; words[2] = 16'h46C0;
        answers[0] = 16'h1111; answers[1] = 16'h2222; answers[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            instr = words[i]; answer = answers[i]; valid = 1'b1;
            t = 0;
            while (!o_ready && t < 20) begin @(negedge CLK); t++; end
            check("b2b_ready", 32'(o_ready), 32'd1);
            acc[i] = cyc;
            @(negedge CLK);
            if (i == 2) valid = 1'b0;
            t = 0;
            while (!o_ldreg && t < 20) begin @(negedge CLK); t++; end
            check("b2b_ldreg", 32'(o_ldreg), 32'd1);
            check("b2b_dr", 32'(o_dr), 32'(i + 1));
            check("b2b_result", 32'(o_result), 32'(answers[i]));
        end
        check("b2b_spacing_01", 32'(acc[1] - acc[0]), 32'd4);
        check("b2b_spacing_12", 32'(acc[2] - acc[1]), 32'd4);
        @(negedge CLK);
        check("b2b_retired", 32'(o_ret), 32'd4);
        check("b2b_idle_ready", 32'(o_ready), 32'd1);

        // Reset in the middle of EXEC on instance B
        @(negedge CLK);
        sel = 1'b1; instr = 16'hEA7F; answer = 16'h5555; valid = 1'b1;
        @(negedge CLK);
        valid = 1'b0;
        @(negedge CLK);
        check("rexec_gate1", 32'(o_gate), 32'd1);
        @(negedge CLK);
        check("rexec_gate2", 32'(o_gate), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("rexec_ready", 32'(o_ready), 32'd1);
        check("rexec_gate", 32'(o_gate), 32'd0);
        check("rexec_ldreg", 32'(o_ldreg), 32'd0);
        check("rexec_done", 32'(o_done), 32'd0);
        check("rexec_addr", 32'(o_addr), 32'd0);
        check("rexec_result", 32'(o_result), 32'd0);
        check("rexec_retired", 32'(o_ret), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("rexec_no_ldreg", 32'(o_ldreg | o_done), 32'd0);
        end

        // Counter wrap on the 4-bit instance: 16 retirements read back as 0
        for (int i = 1; i <= 16; i++) begin
            issue(1'b1, 16'hC600, 16'(i), 3, 2'b00, 3'd3, 8'h00, 7'h00, 16'(i % 16));
        end
        check("wrap_retired", 32'(o_ret), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
